// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Matrix-keypad scanner. Drives one row low at a time, samples the
//   active-low column lines, debounces whole scan frames and reports
//   press/release events with a key code and a 7-segment image.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   column       column lines, active-low (0 = contact closed on driven row)
//   row          row drive, exactly one bit low
//   key_code     index of the last accepted key, r*COLS + c
//   key_valid    one-cycle pulse on an accepted press
//   key_release  one-cycle pulse on an accepted release
//   key_held     high while the accepted state is a single pressed key
//   multi_key    high while the accepted state is two or more keys
//   display      segments {a,b,c,d,e,f,g}, active-high
//   common       display common, tied low
module keypad_scanner #(
    parameter int ROWS     = 4,
    parameter int COLS     = 3,
    parameter int CLK_DIV  = 50,
    parameter int DEBOUNCE = 4,
    parameter int KEY_W    = $clog2(ROWS*COLS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [COLS-1:0]  column,
    output logic [ROWS-1:0]  row,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    output logic             key_release,
    output logic             key_held,
    output logic             multi_key,
    output logic [6:0]       display,
    output logic             common
);
    localparam int TW = $clog2(CLK_DIV);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    typedef enum logic [1:0] {K_NONE, K_KEY, K_MULTI} kind_t;
    typedef struct packed {
        kind_t            kind;
        logic [KEY_W-1:0] code;   // zero unless kind == K_KEY, so == compares whole states
    } cand_t;

    localparam cand_t NONE_C = '{kind: K_NONE, code: '0};

    function automatic logic [6:0] seg_image(input logic [KEY_W-1:0] code);
        case (32'(code))
            0:       seg_image = 7'b0110000;  // 1
            1:       seg_image = 7'b1101101;  // 2
            2:       seg_image = 7'b1111001;  // 3
            3:       seg_image = 7'b0110011;  // 4
            4:       seg_image = 7'b1011011;  // 5
            5:       seg_image = 7'b1011111;  // 6
            6:       seg_image = 7'b1110000;  // 7
            7:       seg_image = 7'b1111111;  // 8
            8:       seg_image = 7'b1111011;  // 9
            9:       seg_image = 7'b1001111;  // E
            10:      seg_image = 7'b1111110;  // 0
            11:      seg_image = 7'b1000111;  // F
            default: seg_image = 7'b0000001;
        endcase
    endfunction

    // ---------------- scan engine ----------------
    logic [COLS-1:0]  col_meta, col_sync;
    logic [TW-1:0]    tick_cnt;
    logic [RW-1:0]    r_idx;
    logic [1:0]       acc_cnt;      // closed contacts so far this frame, saturates at 2
    logic [KEY_W-1:0] acc_code;     // first closed contact this frame

    logic             tick, last_row, frame_end;
    logic [1:0]       row_cnt, sum_cnt;
    logic [2:0]       sum_raw;
    logic [CW-1:0]    row_first;
    logic [KEY_W-1:0] row_code, first_code;
    cand_t            cand;

    assign tick      = (tick_cnt == TW'(CLK_DIV - 1));
    assign last_row  = (r_idx == RW'(ROWS - 1));
    assign frame_end = tick && last_row;
    assign row       = ~(ROWS'(1) << r_idx);
    assign common    = 1'b0;

    // Contacts seen on the row being sampled, folded into the frame totals.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        row_cnt   = 2'd0;
        row_first = '0;
        for (int c = 0; c < COLS; c++) begin
            if (!col_sync[c]) begin
                if (row_cnt == 2'd0) row_first = CW'(c);
                if (row_cnt != 2'd2) row_cnt = row_cnt + 2'd1;
            end
        end
        row_code   = KEY_W'(32'(r_idx) * COLS + 32'(row_first));
        sum_raw    = {1'b0, acc_cnt} + {1'b0, row_cnt};
        sum_cnt    = (sum_raw > 3'd2) ? 2'd2 : sum_raw[1:0];
        first_code = (acc_cnt != 2'd0) ? acc_code : row_code;

        cand = NONE_C;
        if (sum_cnt == 2'd1) cand = '{kind: K_KEY, code: first_code};
        else if (sum_cnt == 2'd2) cand = '{kind: K_MULTI, code: '0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Synchroniser resets to "no contact" so reset never looks like a press.
            col_meta <= '1;
            col_sync <= '1;
            tick_cnt <= '0;
            r_idx    <= '0;
            acc_cnt  <= '0;
            acc_code <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            col_meta <= column;
            col_sync <= col_meta;
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
            if (tick) begin
                r_idx <= last_row ? '0 : r_idx + RW'(1);
                if (last_row) begin
                    acc_cnt  <= '0;
                    acc_code <= '0;
                end else begin
                    acc_cnt  <= sum_cnt;
                    acc_code <= first_code;
                end
            end
        end
    end

    // ---------------- debounce / accepted-state FSM ----------------
    cand_t            prev_cand, prev_nx;
    cand_t            accepted, acc_nx;
    logic [3:0]       stable_cnt, stable_nx;
    logic [KEY_W-1:0] code_nx;
    logic             valid_nx, release_nx;
    logic [6:0]       display_nx;

    always_comb begin
        prev_nx    = prev_cand;
        acc_nx     = accepted;
        stable_nx  = stable_cnt;
        code_nx    = key_code;
        valid_nx   = 1'b0;
        release_nx = 1'b0;
        display_nx = display;
        if (frame_end) begin
            if (cand == prev_cand) begin
                if (stable_cnt != 4'(DEBOUNCE)) stable_nx = stable_cnt + 4'd1;
            end else begin
                stable_nx = 4'd1;
                prev_nx   = cand;
            end
            if (stable_nx == 4'(DEBOUNCE) && cand != accepted) begin
                acc_nx = cand;
                if (cand.kind == K_KEY) begin
                    valid_nx   = 1'b1;
                    code_nx    = cand.code;
                    display_nx = seg_image(cand.code);
                end else if (accepted.kind == K_KEY) begin
                    release_nx = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_cand   <= NONE_C;
            accepted    <= NONE_C;
            stable_cnt  <= '0;
            key_code    <= '0;
            key_valid   <= 1'b0;
            key_release <= 1'b0;
            display     <= 7'b0000000;
        end else begin
            prev_cand   <= prev_nx;
            accepted    <= acc_nx;
            stable_cnt  <= stable_nx;
            key_code    <= code_nx;
            key_valid   <= valid_nx;
            key_release <= release_nx;
            display     <= display_nx;
        end
    end

    assign key_held  = (accepted.kind == K_KEY);
    assign multi_key = (accepted.kind == K_MULTI);

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
//   Bench for keypad_scanner with ROWS=4, COLS=3, CLK_DIV=4, DEBOUNCE=3.
//   A contact-set keypad model drives the columns; a frame-level reference
//   model predicts every output each cycle.
module tb_keypad_scanner;
    localparam int ROWS     = 4;
    localparam int COLS     = 3;
    localparam int CLK_DIV  = 4;
    localparam int DEBOUNCE = 3;
    localparam int KEY_W    = $clog2(ROWS*COLS);
    localparam int FRAME    = ROWS * CLK_DIV;
    localparam int NONE     = -1;
    localparam int MULTI    = -2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [COLS-1:0]  column;
    logic [ROWS-1:0]  row;
    logic [KEY_W-1:0] key_code;
    logic             key_valid, key_release, key_held, multi_key, common;
    logic [6:0]       display;

    logic [ROWS*COLS-1:0] pressed = '0;  // closed contacts, indexed by key code
    bit running = 1'b0;
    int n_checks = 0;
    int n_fail = 0;
    int valid_seen = 0;
    int release_seen = 0;

    always #5 clk = ~clk;

    keypad_scanner #(
        .ROWS(ROWS), .COLS(COLS), .CLK_DIV(CLK_DIV), .DEBOUNCE(DEBOUNCE), .KEY_W(KEY_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .column(column), .row(row),
        .key_code(key_code), .key_valid(key_valid), .key_release(key_release),
        .key_held(key_held), .multi_key(multi_key), .display(display), .common(common)
    );

    // Keypad: a closed contact pulls its column low while its row is driven.
    always_comb begin
        column = '1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (pressed[r*COLS + c] && !row[r]) column[c] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [6:0] seg_img(input int code);
        logic [6:0] t [12] = '{7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                               7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111,
                               7'b1111011, 7'b1001111, 7'b1111110, 7'b1000111};
        return (code >= 0 && code < 12) ? t[code] : 7'b0000001;
    endfunction

    // Reference model: cycle n after reset is a tick when n % CLK_DIV == CLK_DIV-1,
    // sampling row (n / CLK_DIV) % ROWS with the contact set seen two edges earlier.
    int          m_n = 0;
    logic [ROWS*COLS-1:0] h1 = '0, h2 = '0;
    int          frame_q[$];
    int          m_prev = NONE, m_acc = NONE, m_stable = 0, m_code = 0;
    bit          m_valid = 0, m_release = 0;
    logic [6:0]  m_display = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n = 0; h1 = '0; h2 = '0; frame_q.delete();
            m_prev = NONE; m_acc = NONE; m_stable = 0; m_code = 0;
            m_valid = 0; m_release = 0; m_display = '0;
        end else begin
            int r, cand;
            m_valid = 0;
            m_release = 0;
            if (m_n % CLK_DIV == CLK_DIV - 1) begin
                r = (m_n / CLK_DIV) % ROWS;
                for (int c = 0; c < COLS; c++)
                    if (h2[r*COLS + c]) frame_q.push_back(r*COLS + c);
                if (r == ROWS - 1) begin
                    cand = (frame_q.size() == 0) ? NONE :
                           (frame_q.size() == 1) ? frame_q[0] : MULTI;
                    frame_q.delete();
                    if (cand == m_prev) m_stable = (m_stable < DEBOUNCE) ? m_stable + 1 : DEBOUNCE;
                    else begin m_stable = 1; m_prev = cand; end
                    if (m_stable == DEBOUNCE && cand != m_acc) begin
                        if (cand >= 0) begin
                            m_valid = 1; m_code = cand; m_display = seg_img(cand);
                        end else if (m_acc >= 0) begin
                            m_release = 1;
                        end
                        m_acc = cand;
                    end
                end
            end
            h2 = h1;
            h1 = pressed;
            m_n++;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (running) begin
            logic [ROWS-1:0] er;
            er = '1;
            er[(m_n / CLK_DIV) % ROWS] = 1'b0;
            check("row", 32'(row), 32'(er));
            check("key_code", 32'(key_code), m_code);
            check("key_valid", 32'(key_valid), 32'(m_valid));
            check("key_release", 32'(key_release), 32'(m_release));
            check("key_held", 32'(key_held), 32'(m_acc >= 0));
            check("multi_key", 32'(multi_key), 32'(m_acc == MULTI));
            check("display", 32'(display), 32'(m_display));
            check("common", 32'(common), 0);
            check("valid_and_release", 32'(key_valid & key_release), 0);
            if (key_valid) valid_seen++;
            if (key_release) release_seen++;
        end
    end

    task automatic wait_pulse(input string name, input bit want_release, input int budget);
        bit got = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (want_release ? key_release : key_valid) begin
                got = 1;
                break;
            end
        end
        check(name, 32'(got), 1);
    endtask

    initial begin
        int v0, r0;
        #1 rst_n = 1'b0;
        #1 running = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_row", 32'(row), 32'(4'b1110));
        check("reset_display", 32'(display), 0);
        check("reset_code", 32'(key_code), 0);
        rst_n = 1'b1;

        // Idle: ten frames with no contacts.
        v0 = valid_seen; r0 = release_seen;
        repeat (10 * FRAME) @(negedge clk);
        check("idle_valid_count", valid_seen - v0, 0);
        check("idle_release_count", release_seen - r0, 0);
        check("idle_display", 32'(display), 0);

        // Single key r=1,c=2 (code 5).
        v0 = valid_seen;
        pressed[5] = 1'b1;
        wait_pulse("press5_latency", 1'b0, 4 * FRAME + 3);
        check("press5_code", 32'(key_code), 5);
        check("press5_held", 32'(key_held), 1);
        check("press5_display", 32'(display), 32'(7'b1011111));
        repeat (5 * FRAME) @(negedge clk);
        check("press5_single_valid", valid_seen - v0, 1);
        pressed[5] = 1'b0;
        wait_pulse("release5_latency", 1'b1, 4 * FRAME + 3);
        check("release5_held", 32'(key_held), 0);
        check("release5_code", 32'(key_code), 5);
        check("release5_display", 32'(display), 32'(7'b1011111));

        // Bounce: code 0 toggled every frame.
        repeat (2 * FRAME) @(negedge clk);
        v0 = valid_seen; r0 = release_seen;
        for (int i = 0; i < 8; i++) begin
            pressed[0] = ~pressed[0];
            repeat (FRAME) @(negedge clk);
        end
        pressed[0] = 1'b0;
        repeat (5 * FRAME) @(negedge clk);
        check("bounce_valid_count", valid_seen - v0, 0);
        check("bounce_release_count", release_seen - r0, 0);

        // Code 0 held, code 10 added then dropped.
        pressed[0] = 1'b1;
        wait_pulse("press0_latency", 1'b0, 4 * FRAME + 3);
        check("press0_code", 32'(key_code), 0);
        check("press0_display", 32'(display), 32'(7'b0110000));
        pressed[10] = 1'b1;
        wait_pulse("multi_release", 1'b1, 4 * FRAME + 3);
        check("multi_on", 32'(multi_key), 1);
        check("multi_held", 32'(key_held), 0);
        pressed[10] = 1'b0;
        wait_pulse("multi_drop_valid", 1'b0, 4 * FRAME + 3);
        check("multi_drop_code", 32'(key_code), 0);
        check("multi_off", 32'(multi_key), 0);
        pressed[0] = 1'b0;
        wait_pulse("release0", 1'b1, 4 * FRAME + 3);

        // Code 7 held across a mid-frame reset.
        pressed[7] = 1'b1;
        wait_pulse("press7_latency", 1'b0, 4 * FRAME + 3);
        check("press7_code", 32'(key_code), 7);
        check("press7_display", 32'(display), 32'(7'b1111111));
        repeat (FRAME / 2 + 1) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midreset_row", 32'(row), 32'(4'b1110));
        check("midreset_code", 32'(key_code), 0);
        check("midreset_held", 32'(key_held), 0);
        check("midreset_display", 32'(display), 0);
        check("midreset_multi", 32'(multi_key), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_pulse("press7_after_reset", 1'b0, 4 * FRAME + 3);
        check("press7_after_reset_code", 32'(key_code), 7);
        pressed = '0;
        repeat (5 * FRAME) @(negedge clk);

        running = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
